// File: rtl/stepper_pkg.sv
// Shared definitions for stepper coil drivers: FSM state encoding, the
// half-step coil table and the phase-advance rule.
package stepper_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DWELL = 2'd1,
      ST_HOLD  = 2'd2
   } step_state_t;

   localparam int PHASE_W = 3;
   localparam int COIL_W  = 4;

   // Index -> {B_n, A_n, B, A}; entry 0 is the rightmost element.
   localparam logic [7:0][COIL_W-1:0] COIL_TABLE = {
      4'b1001, 4'b1000, 4'b1100, 4'b0100,
      4'b0110, 4'b0010, 4'b0011, 4'b0001
   };

   // Full-step from an even (single-coil) index moves by one so the motor
   // lands on an odd (two-phase-on) index; afterwards it strides by two.
   function automatic logic [PHASE_W-1:0] next_phase(
      input logic [PHASE_W-1:0] cur,
      input logic               dir_fwd,
      input logic               half
   );
      logic [PHASE_W-1:0] delta;
      delta = (half || !cur[0]) ? PHASE_W'(1) : PHASE_W'(2);
      return dir_fwd ? cur + delta : cur - delta;
   endfunction

endpackage

// File: rtl/step_phase_lut.sv
// Combinational phase index -> coil pattern lookup, shared by coil drivers.
module step_phase_lut
   import stepper_pkg::*;
(
   input  logic [PHASE_W-1:0] index,
   output logic [COIL_W-1:0]  coils
);

   generate
      for (genvar gi = 0; gi < COIL_W; gi++) begin : g_coil
         assign coils[gi] = COIL_TABLE[index][gi];
      end
   endgenerate

endmodule

// File: rtl/stepper_phase_driver.sv
// Four-coil stepper driver: accepts single-step requests, holds each pattern
// for a minimum dwell, and de-energizes on idle timeout or loss of enable.
module stepper_phase_driver
   import stepper_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int IDLE_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               step_req,
   input  logic               step_dir,
   input  logic               half_step,
   input  logic [CNT_W-1:0]   dwell,
   output logic               step_ack,
   output logic               busy,
   output logic               energized,
   output logic [PHASE_W-1:0] phase,
   output logic [COIL_W-1:0]  coils
);

   localparam bit               TIMEOUT_EN = (IDLE_CYCLES != 0);
   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);

   step_state_t        state_reg;
   logic [PHASE_W-1:0] phase_reg;
   logic [CNT_W-1:0]   dwell_cnt_reg;
   logic [CNT_W-1:0]   idle_cnt_reg;
   logic               step_ack_reg;
   logic               busy_reg;
   logic               energized_reg;
   logic [COIL_W-1:0]  coils_reg;

   logic               accept;
   logic [PHASE_W-1:0] phase_next;
   logic [COIL_W-1:0]  coils_next;
   logic [CNT_W-1:0]   dwell_load;

   assign accept     = (state_reg == ST_OFF || state_reg == ST_HOLD) && enable && step_req;
   assign phase_next = next_phase(phase_reg, step_dir, half_step);
   // A zero dwell still holds the new pattern for one cycle.
   assign dwell_load = (dwell == '0) ? '0 : dwell - CNT_W'(1);

   step_phase_lut u_lut (
      .index (phase_next),
      .coils (coils_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_OFF;
         phase_reg     <= '0;
         dwell_cnt_reg <= '0;
         idle_cnt_reg  <= '0;
         step_ack_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         energized_reg <= 1'b0;
         coils_reg     <= '0;
      end else begin
         step_ack_reg <= 1'b0;
         if (accept) begin
            state_reg     <= ST_DWELL;
            phase_reg     <= phase_next;
            dwell_cnt_reg <= dwell_load;
            step_ack_reg  <= 1'b1;
            busy_reg      <= 1'b1;
            energized_reg <= 1'b1;
            coils_reg     <= coils_next;
         end else begin
            case (state_reg)
               ST_OFF: begin
                  busy_reg      <= 1'b0;
                  energized_reg <= 1'b0;
                  coils_reg     <= '0;
               end
               ST_DWELL: begin
                  if (!enable) begin
                     state_reg     <= ST_OFF;
                     busy_reg      <= 1'b0;
                     energized_reg <= 1'b0;
                     coils_reg     <= '0;
                  end else if (dwell_cnt_reg == '0) begin
                     state_reg    <= ST_HOLD;
                     idle_cnt_reg <= '0;
                     busy_reg     <= 1'b0;
                  end else begin
                     dwell_cnt_reg <= dwell_cnt_reg - CNT_W'(1);
                  end
               end
               ST_HOLD: begin
                  // Reaching here means no accept this cycle, so timeout may fire.
                  if (!enable || (TIMEOUT_EN && idle_cnt_reg == IDLE_LAST)) begin
                     state_reg     <= ST_OFF;
                     busy_reg      <= 1'b0;
                     energized_reg <= 1'b0;
                     coils_reg     <= '0;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                  end
               end
               default: begin
                  state_reg     <= ST_OFF;
                  busy_reg      <= 1'b0;
                  energized_reg <= 1'b0;
                  coils_reg     <= '0;
               end
            endcase
         end
      end
   end

   assign step_ack  = step_ack_reg;
   assign busy      = busy_reg;
   assign energized = energized_reg;
   assign phase     = phase_reg;
   assign coils     = coils_reg;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Directed bench for stepper_phase_driver with hand-computed phases and coils.
module tb_stepper_phase_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        step_req = 1'b0;
   logic        step_dir = 1'b1;
   logic        half_step = 1'b1;
   logic [15:0] dwell = 16'd0;
   logic        step_ack;
   logic        busy;
   logic        energized;
   logic [2:0]  phase;
   logic [3:0]  coils;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_ack_cyc = 0;

   stepper_phase_driver #(.CNT_W(16), .IDLE_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .step_req  (step_req),
      .step_dir  (step_dir),
      .half_step (half_step),
      .dwell     (dwell),
      .step_ack  (step_ack),
      .busy      (busy),
      .energized (energized),
      .phase     (phase),
      .coils     (coils)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_ack(input string tag);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (step_ack) return;
      end
      check_eq({tag, "_ack_timeout"}, 32'd0, 32'd1);
   endtask

   // Waits for one accepted step, checks its pattern, dwell length and ack spacing.
   task automatic step_once(input string tag, input logic [2:0] ep, input logic [3:0] ec,
                            input int ebusy, input int egap, input bit last);
      int n;
      wait_ack(tag);
      if (last) step_req = 1'b0;
      $display("step %s cyc %0d phase %0d coils %b", tag, cyc, phase, coils);
      check_eq({tag, "_phase"}, 32'(phase), 32'(ep));
      check_eq({tag, "_coils"}, 32'(coils), 32'(ec));
      check_eq({tag, "_energized"}, 32'(energized), 32'd1);
      if (egap != 0) check_eq({tag, "_gap"}, 32'(cyc - last_ack_cyc), 32'(egap));
      last_ack_cyc = cyc;
      n = 0;
      for (int i = 0; i < 40 && busy; i++) begin
         n++;
         tick();
      end
      check_eq({tag, "_busy_len"}, 32'(n), 32'(ebusy));
   endtask

   initial begin
      int n;
      // Reset state
      tick();
      do_reset();
      check_eq("rst_ack", 32'(step_ack), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_energized", 32'(energized), 32'd0);
      check_eq("rst_phase", 32'(phase), 32'd0);
      check_eq("rst_coils", 32'(coils), 32'd0);

      // 1: half-step forward, dwell 4, request held
      enable = 1'b1; half_step = 1'b1; step_dir = 1'b1; dwell = 16'd4; step_req = 1'b1;
      step_once("hs_fwd1", 3'd1, 4'b0011, 4, 0, 1'b0);
      step_once("hs_fwd2", 3'd2, 4'b0010, 4, 5, 1'b0);
      step_once("hs_fwd3", 3'd3, 4'b0110, 4, 5, 1'b1);

      // 2: full-step forward from 0, wraps 7 -> 1
      do_reset();
      half_step = 1'b0; step_dir = 1'b1; dwell = 16'd1; step_req = 1'b1;
      step_once("fs_fwd1", 3'd1, 4'b0011, 1, 0, 1'b0);
      step_once("fs_fwd2", 3'd3, 4'b0110, 1, 2, 1'b0);
      step_once("fs_fwd3", 3'd5, 4'b1100, 1, 2, 1'b0);
      step_once("fs_fwd4", 3'd7, 4'b1001, 1, 2, 1'b0);
      step_once("fs_fwd5", 3'd1, 4'b0011, 1, 2, 1'b1);

      // 3: half-step reverse from 0, wraps 0 -> 7
      do_reset();
      half_step = 1'b1; step_dir = 1'b0; dwell = 16'd3; step_req = 1'b1;
      step_once("hs_rev1", 3'd7, 4'b1001, 3, 0, 1'b0);
      step_once("hs_rev2", 3'd6, 4'b1000, 3, 4, 1'b1);

      // 4: enable drops on the second cycle of an 8-cycle dwell
      do_reset();
      step_dir = 1'b1; dwell = 16'd8; step_req = 1'b1;
      wait_ack("en_drop");
      check_eq("en_drop_phase0", 32'(phase), 32'd1);
      tick();
      check_eq("en_drop_busy_mid", 32'(busy), 32'd1);
      enable = 1'b0;
      tick();
      $display("enable drop cyc %0d coils %b busy %0d energized %0d", cyc, coils, busy, energized);
      check_eq("en_drop_coils", 32'(coils), 32'd0);
      check_eq("en_drop_busy", 32'(busy), 32'd0);
      check_eq("en_drop_energized", 32'(energized), 32'd0);
      check_eq("en_drop_phase", 32'(phase), 32'd1);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (step_ack) n++;
      end
      check_eq("en_low_acks", 32'(n), 32'd0);
      check_eq("en_low_energized", 32'(energized), 32'd0);
      step_req = 1'b0;
      enable = 1'b1;

      // 5: idle timeout after 10 HOLD cycles, then resume from retained phase
      dwell = 16'd2; step_req = 1'b1;
      step_once("idle_step", 3'd2, 4'b0010, 2, 0, 1'b1);
      n = 0;
      for (int i = 0; i < 40 && energized; i++) begin
         n++;
         tick();
      end
      $display("idle timeout cyc %0d hold_cycles %0d", cyc, n);
      check_eq("idle_hold_len", 32'(n), 32'd10);
      check_eq("idle_coils", 32'(coils), 32'd0);
      check_eq("idle_phase", 32'(phase), 32'd2);
      step_req = 1'b1;
      step_once("idle_resume", 3'd3, 4'b0110, 2, 0, 1'b1);

      // 6: dwell 0 gives one busy cycle; reset wins over a step request
      do_reset();
      dwell = 16'd0; step_req = 1'b1;
      step_once("dwell0", 3'd1, 4'b0011, 1, 0, 1'b1);
      dwell = 16'd8; step_req = 1'b1;
      wait_ack("rst_mid");
      tick();
      reset = 1'b1;
      tick();
      $display("reset mid-dwell cyc %0d ack %0d phase %0d coils %b", cyc, step_ack, phase, coils);
      check_eq("rst_req_ack", 32'(step_ack), 32'd0);
      check_eq("rst_req_busy", 32'(busy), 32'd0);
      check_eq("rst_req_phase", 32'(phase), 32'd0);
      check_eq("rst_req_coils", 32'(coils), 32'd0);
      check_eq("rst_req_energized", 32'(energized), 32'd0);
      reset = 1'b0;
      step_req = 1'b0;
      tick();
      check_eq("post_rst_ack", 32'(step_ack), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
